// File: rtl/win_scanner_pkg.sv
// Shared codes for the board scanner: direction and colour encodings plus the FSM state type.
package win_pkg;
  localparam logic [1:0] DIR_ROW  = 2'd0;
  localparam logic [1:0] DIR_COL  = 2'd1;
  localparam logic [1:0] DIR_DIAG = 2'd2;
  localparam logic [1:0] DIR_ANTI = 2'd3;

  localparam int BLACK = 0;
  localparam int WHITE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
endpackage

// File: rtl/win_scanner_if.sv
// Scanner <-> controller/board-store bundle; the scanner takes the slave side.
interface win_scanner_if #(
  parameter int BOARD_SIZE = 15,
  parameter int WIN_LEN    = 5,
  parameter int LINE_W     = 2*WIN_LEN-1,
  parameter int CW         = $clog2(BOARD_SIZE)
);
  logic                         clr;
  logic                         start;
  logic [3:0][LINE_W-1:0]       black_line;
  logic [3:0][LINE_W-1:0]       white_line;
  logic [CW-1:0]                get_i;
  logic [CW-1:0]                get_j;
  logic                         busy;
  logic                         done;
  logic                         win_found;
  logic [1:0]                   winner;
  logic [CW-1:0]                win_i;
  logic [CW-1:0]                win_j;
  logic [1:0]                   win_dir;

  modport master (
    output clr, start, black_line, white_line,
    input  get_i, get_j, busy, done, win_found, winner, win_i, win_j, win_dir
  );
  modport slave (
    input  clr, start, black_line, white_line,
    output get_i, get_j, busy, done, win_found, winner, win_i, win_j, win_dir
  );
endinterface

// File: rtl/win_scanner_run_detect.sv
// Flags a window that contains WIN_LEN contiguous stones anywhere among its LINE_W bits.
module run_detect #(
  parameter int WIN_LEN = 5,
  parameter int LINE_W  = 2*WIN_LEN-1
) (
  input  logic [LINE_W-1:0] i_line,
  output logic              o_hit
);
  always_comb begin
    o_hit = 1'b0;
    for (int s = 0; s <= LINE_W-WIN_LEN; s++)
      if (&i_line[s +: WIN_LEN]) o_hit = 1'b1;
  end
endmodule

// File: rtl/win_scanner.sv
// Row-major N x N board scanner reporting winner colour, first winning cell and direction.
// Define WIN_SCANNER_EARLY_EXIT_EN to stop the scan at the first cell with any hit.
module win_scanner
  import win_pkg::*;
#(
  parameter int BOARD_SIZE = 15,
  parameter int WIN_LEN    = 5,
  parameter int LINE_W     = 2*WIN_LEN-1,
  parameter int CW         = $clog2(BOARD_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  win_scanner_if.slave  bus
);
  state_t        r_state;
  logic [CW-1:0] r_get_i, r_get_j, r_win_i, r_win_j;
  logic          r_busy, r_done;
  logic [1:0]    r_winner, r_win_dir;

  logic [3:0]    w_hit_b, w_hit_w, w_hit_any;
  logic [1:0]    w_col, w_dir;
  logic          w_any, w_last, w_end;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    run_detect #(.WIN_LEN(WIN_LEN), .LINE_W(LINE_W)) u_blk (
      .i_line(bus.black_line[d]), .o_hit(w_hit_b[d]));
    run_detect #(.WIN_LEN(WIN_LEN), .LINE_W(LINE_W)) u_wht (
      .i_line(bus.white_line[d]), .o_hit(w_hit_w[d]));
  end

  assign w_hit_any = w_hit_b | w_hit_w;
  assign w_any     = |w_hit_any;
  assign w_last    = (r_get_i == CW'(BOARD_SIZE-1)) && (r_get_j == CW'(BOARD_SIZE-1));
`ifdef WIN_SCANNER_EARLY_EXIT_EN
  assign w_end     = w_last || w_any;
`else
  assign w_end     = w_last;
`endif

  always_comb begin
    w_col        = '0;
    w_col[BLACK] = |w_hit_b;
    w_col[WHITE] = |w_hit_w;
  end

  // Lowest direction index wins when several fire on the same cell.
  always_comb begin
    w_dir = DIR_ROW;
    for (int d = 3; d >= 0; d--)
      if (w_hit_any[d]) w_dir = 2'(d);
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_get_i   <= '0;
      r_get_j   <= '0;
      r_winner  <= '0;
      r_win_i   <= '0;
      r_win_j   <= '0;
      r_win_dir <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state   <= S_SCAN;
            r_busy    <= 1'b1;
            r_get_i   <= '0;
            r_get_j   <= '0;
            r_winner  <= '0;
            r_win_i   <= '0;
            r_win_j   <= '0;
            r_win_dir <= '0;
          end
        end
        S_SCAN: begin
          if (w_any) begin
            r_winner <= r_winner | w_col;
            // An all-zero winner means no earlier cell hit, so this one is the first.
            if (r_winner == 2'b00) begin
              r_win_i   <= r_get_i;
              r_win_j   <= r_get_j;
              r_win_dir <= w_dir;
            end
          end
          if (w_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_get_i <= '0;
            r_get_j <= '0;
          end else if (r_get_j == CW'(BOARD_SIZE-1)) begin
            r_get_j <= '0;
            r_get_i <= r_get_i + CW'(1);
          end else begin
            r_get_j <= r_get_j + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.get_i     = r_get_i;
  assign bus.get_j     = r_get_j;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.winner    = r_winner;
  assign bus.win_found = |r_winner;
  assign bus.win_i     = r_win_i;
  assign bus.win_j     = r_win_j;
  assign bus.win_dir   = r_win_dir;
endmodule
